key_debounce: RTL and testbench

- Conditions a raw, active-low, asynchronous push-button (board KEY) into clean single-cycle events for the random-number FSM.
- o_press_pulse drives the FSM's i_start directly.
- Synchronises the key, rejects bounce with a stable-count filter, and produces a debounced level plus one-cycle press/release pulses.
- One instance per key.

---
 rtl/key_debounce_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/key_debounce.sv | 100 ++++++++++
 tb/tb_key_debounce.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Purpose: shared types and constants for the push-button debouncers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_debounce_pkg;

  // Debouncer FSM states: two stable levels, each with its own qualify state.
  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  // 10 ms of stability at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Short filter so simulations finish quickly.
  localparam int DEBOUNCE_CYCLES_SIM = 4;

  // The debounced level stays "pressed" while a release is still being qualified.
  function automatic logic is_pressed_state(input state_t s);
    return (s == S_PRESSED) || (s == S_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchroniser for a single asynchronous board input.
// Latency: 2 i_clk edges from the input being sampled to o_q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Plain flop-to-flop chain: nothing may sit between the two stages.
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Both stages reset to the input's idle level so no false edge follows reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Purpose: turns a raw active-low key into a debounced level plus press/release pulses.
// Latency: pulse appears in the cycle after edge DEBOUNCE_CYCLES+2 (edge 0 = first low sample).
// Backpressure: none; pulses last one cycle and the consumer must sample every cycle.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic k_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;

  // Key idles high (released), so the synchroniser resets to 1.
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_key_n),
    .o_q   (k_s)
  );

  // Next-state logic: a new level must survive DEBOUNCE_CYCLES+1 samples; any
  // opposite sample falls back to the previous stable state.
  always_comb begin
    state_d         = state_q;
    cnt_d           = '0;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    case (state_q)
      S_RELEASED: begin
        if (!k_s) state_d = S_PRESS_WAIT;
      end
      S_PRESS_WAIT: begin
        if (k_s) begin
          state_d = S_RELEASED;
        end else if (cnt_q == CNT_MAX) begin
          state_d       = S_PRESSED;
          press_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PRESSED: begin
        if (k_s) state_d = S_RELEASE_WAIT;
      end
      S_RELEASE_WAIT: begin
        if (!k_s) begin
          state_d = S_PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d         = S_RELEASED;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_RELEASED;
    endcase
    // Level is registered from the next state so it changes with the pulse.
    pressed_d = is_pressed_state(state_d);
  end

  // State, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= S_RELEASED;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign o_pressed       = pressed_q;
  assign o_press_pulse   = press_pulse_q;
  assign o_release_pulse = release_pulse_q;

endmodule

// File: tb/tb_key_debounce.sv
// Purpose: self-checking bench for key_debounce with the short simulation filter.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_debounce;
  import key_debounce_pkg::*;

  localparam int D = DEBOUNCE_CYCLES_SIM;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic i_key_n = 1'b0;
  logic o_pressed, o_press_pulse, o_release_pulse;

  int checks = 0;
  int failures = 0;

  // Reference model: accepted level plus the length of the current run of
  // samples disagreeing with it; raw samples reach the filter two edges late.
  logic delay_q[$];
  logic m_pressed, m_press_pulse, m_release_pulse;
  int   m_run;

  // Per-segment observations.
  int ps_cnt, rl_cnt, ps_edge, rl_edge;

  key_debounce #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_key_n         (i_key_n),
    .o_pressed       (o_pressed),
    .o_press_pulse   (o_press_pulse),
    .o_release_pulse (o_release_pulse)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    delay_q = {1'b1, 1'b1};
    m_pressed = 1'b0;
    m_press_pulse = 1'b0;
    m_release_pulse = 1'b0;
    m_run = 0;
  endtask

  task automatic model_edge(input logic raw);
    logic seen_pressed;
    seen_pressed = !delay_q.pop_front();
    delay_q.push_back(raw);
    m_press_pulse = 1'b0;
    m_release_pulse = 1'b0;
    if (seen_pressed != m_pressed) begin
      m_run++;
      if (m_run == D + 1) begin
        m_pressed = seen_pressed;
        m_run = 0;
        if (seen_pressed) m_press_pulse = 1'b1;
        else m_release_pulse = 1'b1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  // Hold the key at one level for n edges, checking every cycle; entered at a negedge.
  task automatic seg(input logic key, input int n, input string tag);
    ps_cnt = 0; rl_cnt = 0; ps_edge = -1; rl_edge = -1;
    for (int i = 0; i < n; i++) begin
      i_key_n = key;
      @(posedge i_clk);
      model_edge(key);
      @(negedge i_clk);
      chk({tag, ".pressed"}, o_pressed, m_pressed);
      chk({tag, ".press_pulse"}, o_press_pulse, m_press_pulse);
      chk({tag, ".release_pulse"}, o_release_pulse, m_release_pulse);
      if (o_press_pulse) begin
        if (ps_cnt == 0) ps_edge = i;
        ps_cnt++;
      end
      if (o_release_pulse) begin
        if (rl_cnt == 0) rl_edge = i;
        rl_cnt++;
      end
    end
  endtask

  // Asynchronous reset pulse of one clock, asserted mid-cycle; entered at a negedge.
  task automatic reset_pulse(input logic key, input string tag);
    i_key_n = key;
    #2 i_rst = 1'b1;
    #1;
    chk({tag, ".async_pressed"}, o_pressed, 0);
    chk({tag, ".async_press_pulse"}, o_press_pulse, 0);
    chk({tag, ".async_release_pulse"}, o_release_pulse, 0);
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    chk({tag, ".held_pressed"}, o_pressed, 0);
    chk({tag, ".held_press_pulse"}, o_press_pulse, 0);
    chk({tag, ".held_release_pulse"}, o_release_pulse, 0);
    i_rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge i_clk);

    // Reset with the key held down.
    reset_pulse(1'b0, "rst_init");

    // Clean press.
    seg(1'b0, 20, "press");
    chk("press.pulse_count", ps_cnt, 1);
    chk("press.pulse_edge", ps_edge, D + 2);
    chk("press.no_release", rl_cnt, 0);
    chk("press.level_end", o_pressed, 1);

    // Clean release.
    seg(1'b1, 20, "release");
    chk("release.pulse_count", rl_cnt, 1);
    chk("release.pulse_edge", rl_edge, D + 2);
    chk("release.no_press", ps_cnt, 0);
    chk("release.level_end", o_pressed, 0);

    // Press bounce that never qualifies.
    seg(1'b0, 3, "bnc_a");
    chk("bnc_a.no_press", ps_cnt, 0);
    seg(1'b1, 1, "bnc_b");
    chk("bnc_b.no_press", ps_cnt, 0);
    seg(1'b0, 2, "bnc_c");
    chk("bnc_c.no_press", ps_cnt, 0);
    seg(1'b1, 12, "bnc_d");
    chk("bnc_d.no_press", ps_cnt, 0);
    chk("bnc_d.level", o_pressed, 0);

    // Release bounce from the pressed state.
    seg(1'b0, 20, "rb_press");
    chk("rb_press.pulse_count", ps_cnt, 1);
    seg(1'b1, 2, "rb_a");
    chk("rb_a.no_release", rl_cnt, 0);
    seg(1'b0, 1, "rb_b");
    chk("rb_b.no_release", rl_cnt, 0);
    seg(1'b1, 20, "rb_c");
    chk("rb_c.pulse_count", rl_cnt, 1);
    chk("rb_c.pulse_edge", rl_edge, D + 2);

    // Reset while pressed, key still held afterwards.
    seg(1'b0, 20, "mid_press");
    chk("mid_press.level", o_pressed, 1);
    reset_pulse(1'b0, "rst_mid");
    seg(1'b0, 20, "after_rst");
    chk("after_rst.pulse_count", ps_cnt, 1);
    chk("after_rst.pulse_edge", ps_edge, D + 2);
    chk("after_rst.no_release", rl_cnt, 0);

    // Random bursts of random length around the filter threshold.
    for (int b = 0; b < 200; b++) begin
      seg(1'($urandom_range(0, 1)), int'($urandom_range(1, 2 * D + 2)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
